regfile_wb_sched: RTL and testbench

Writeback scheduler for the 32-entry register file: shares its single write port among `NUM_REQ` writeback requesters (ALU, load unit, CSR unit, ...) with round-robin arbitration and a registered write stage. It also holds a busy scoreboard so issue logic can stall on read-after-write hazards against in-flight results. It sits between the execution units and the register file's `w0en`/`w0addr`/`w0val` port.

---
 rtl/regfile_wb_sched_pkg.sv | 27 ++
 rtl/regfile_wb_sched_rr_arbiter.sv | 45 ++++
 rtl/regfile_wb_sched.sv | 98 +++++++++
 tb/tb_regfile_wb_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_sched_pkg.sv
// Shared core types for the writeback path: register index, result value and
// the registered write-stage entry, plus a small ring-index helper.
package regfile_wb_sched_pkg;

    localparam int XLEN          = 32;
    localparam int NUM_ARCH_REGS = 32;
    localparam int REG_IDX_W     = $clog2(NUM_ARCH_REGS);

    typedef logic [REG_IDX_W-1:0] uop_reg_t;
    typedef logic [XLEN-1:0]      uop_val_t;

    localparam uop_reg_t REG_X0 = '0;

    typedef struct packed {
        logic     en;
        uop_reg_t addr;
        uop_val_t val;
    } wb_entry_t;

    // Position 'off' steps past 'base' on a ring of n slots; off is below n.
    function automatic int rrIndex(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer, which
// moves just past the winner whenever the grant is taken.
module rr_arbiter
    import regfile_wb_sched_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_gntIdx;
    logic [N-1:0]  w_gnt;
    logic          w_found;

    always_comb begin
        w_gnt    = '0;
        w_gntIdx = '0;
        w_found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[rrIndex(int'(r_ptr), k, N)]) begin
                w_gnt[rrIndex(int'(r_ptr), k, N)] = 1'b1;
                w_gntIdx = PW'(rrIndex(int'(r_ptr), k, N));
                w_found  = 1'b1;
            end
        end
    end

    assign gnt = w_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= (w_gntIdx == PW'(N - 1)) ? '0 : (w_gntIdx + 1'b1);
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: arbitrates the register-file write port among the
// execution units and tracks in-flight destinations for RAW stalls.
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  uop_reg_t           req_rd  [NUM_REQ],
    input  uop_val_t           req_val [NUM_REQ],
    input  logic               issue_en,
    input  uop_reg_t           issue_rd,
    input  uop_reg_t           rs0_addr,
    input  uop_reg_t           rs1_addr,
    output logic               rs0_busy,
    output logic               rs1_busy,
    output logic               w0en,
    output uop_reg_t           w0addr,
    output uop_val_t           w0val
);

    logic [NUM_REQ-1:0]       w_gnt;
    logic                     w_accept;
    uop_reg_t                 w_selRd;
    uop_val_t                 w_selVal;
    wb_entry_t                r_wb;
    logic [NUM_ARCH_REGS-1:0] r_busy;
    logic [NUM_ARCH_REGS-1:0] w_busyNext;

    rr_arbiter #(
        .N       (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (w_accept),
        .gnt     (w_gnt)
    );

    // Grants are suppressed while reset is held so no unit believes it was accepted.
    assign req_ready = rst ? '0 : w_gnt;
    assign w_accept  = |req_ready;

    always_comb begin
        w_selRd  = REG_X0;
        w_selVal = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                w_selRd  = req_rd[i];
                w_selVal = req_val[i];
            end
        end
    end

    // Results to x0 are consumed here but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb <= '0;
        end else if (w_accept) begin
            r_wb.en   <= (w_selRd != REG_X0);
            r_wb.addr <= w_selRd;
            r_wb.val  <= w_selVal;
        end else begin
            r_wb.en <= 1'b0;
        end
    end

    assign w0en   = r_wb.en;
    assign w0addr = r_wb.addr;
    assign w0val  = r_wb.val;

    // Clear first so a same-edge issue to the register being written keeps it busy.
    always_comb begin
        w_busyNext = r_busy;
        if (r_wb.en) begin
            w_busyNext[r_wb.addr] = 1'b0;
        end
        if (issue_en && (issue_rd != REG_X0)) begin
            w_busyNext[issue_rd] = 1'b1;
        end
        w_busyNext[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    assign rs0_busy = r_busy[rs0_addr];
    assign rs1_busy = r_busy[rs1_addr];

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed scenarios plus random
// traffic, with expected writes queued and checked by a separate monitor.
module tb_regfile_wb_sched;
    import regfile_wb_sched_pkg::*;

    localparam int N = 3;

    typedef struct {
        int       tag;
        uop_reg_t addr;
        uop_val_t val;
    } expWrite_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] reqValid = '0;
    logic [N-1:0] reqReady;
    uop_reg_t     reqRd  [N];
    uop_val_t     reqVal [N];
    logic         issueEn = 1'b0;
    uop_reg_t     issueRd = '0;
    uop_reg_t     rs0Addr = '0;
    uop_reg_t     rs1Addr = '0;
    logic         rs0Busy, rs1Busy;
    logic         w0en;
    uop_reg_t     w0addr;
    uop_val_t     w0val;

    int testsRun = 0;
    int testsFailed = 0;
    int cycleCount = 0;

    // Reference model state: pending offers per unit, pointer, busy set, write in flight.
    logic     pend [N];
    uop_reg_t pRd  [N];
    uop_val_t pVal [N];
    int       mPtr = 0;
    bit       mBusy [NUM_ARCH_REGS];
    bit       mW0en = 0;
    uop_reg_t mW0addr = '0;
    expWrite_t expQ[$];

    regfile_wb_sched #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid),
        .req_ready (reqReady),
        .req_rd    (reqRd),
        .req_val   (reqVal),
        .issue_en  (issueEn),
        .issue_rd  (issueRd),
        .rs0_addr  (rs0Addr),
        .rs1_addr  (rs1Addr),
        .rs0_busy  (rs0Busy),
        .rs1_busy  (rs1Busy),
        .w0en      (w0en),
        .w0addr    (w0addr),
        .w0val     (w0val)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCount);
        end
    endtask

    task automatic failNow(input string name, input int act, input int exp);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycleCount);
    endtask

    task automatic modelReset();
        mPtr  = 0;
        mW0en = 0;
        mW0addr = '0;
        for (int r = 0; r < NUM_ARCH_REGS; r++) mBusy[r] = 0;
        expQ.delete();
    endtask

    task automatic applyStimulus(input logic iEn, input uop_reg_t iRd,
                                 input uop_reg_t a0, input uop_reg_t a1);
        for (int i = 0; i < N; i++) begin
            reqValid[i] = pend[i];
            reqRd[i]    = pRd[i];
            reqVal[i]   = pVal[i];
        end
        issueEn = iEn;
        issueRd = iRd;
        rs0Addr = a0;
        rs1Addr = a1;
    endtask

    // Compares the combinational outputs, then advances the model over the coming edge.
    task automatic checkOutput();
        int winner;
        logic [N-1:0] expGnt;
        winner = -1;
        expGnt = '0;
        for (int k = 0; k < N; k++) begin
            if (winner < 0 && pend[(mPtr + k) % N]) winner = (mPtr + k) % N;
        end
        if (winner >= 0) expGnt[winner] = 1'b1;
        checkEq("req_ready", 64'(reqReady), 64'(expGnt));
        checkEq("rs0_busy", 64'(rs0Busy), 64'(mBusy[rs0Addr]));
        checkEq("rs1_busy", 64'(rs1Busy), 64'(mBusy[rs1Addr]));
        if (mW0en) mBusy[mW0addr] = 0;
        if (issueEn && issueRd != 0) mBusy[issueRd] = 1;
        mW0en = 0;
        if (winner >= 0) begin
            mPtr = (winner + 1) % N;
            if (pRd[winner] != 0) begin
                expQ.push_back('{tag: cycleCount + 1, addr: pRd[winner], val: pVal[winner]});
                mW0en   = 1;
                mW0addr = pRd[winner];
            end
            pend[winner] = 1'b0;
        end
    endtask

    task automatic stepCycle(input logic iEn, input uop_reg_t iRd,
                             input uop_reg_t a0, input uop_reg_t a1);
        applyStimulus(iEn, iRd, a0, a1);
        #3;
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int i, input uop_reg_t rd, input uop_val_t val);
        pend[i] = 1'b1;
        pRd[i]  = rd;
        pVal[i] = val;
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write and be on time.
    always @(negedge clk) begin
        if (!rst) begin
            if (w0en) begin
                if (expQ.size() == 0) begin
                    failNow("w0en_spurious", 1, 0);
                end else begin
                    expWrite_t e;
                    e = expQ.pop_front();
                    checkEq("w0_cycle", 64'(cycleCount), 64'(e.tag));
                    checkEq("w0addr", 64'(w0addr), 64'(e.addr));
                    checkEq("w0val", 64'(w0val), 64'(e.val));
                end
            end else if (expQ.size() > 0 && expQ[0].tag <= cycleCount) begin
                void'(expQ.pop_front());
                failNow("w0en_missing", 0, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pRd[i]  = '0;
            pVal[i] = '0;
            reqRd[i]  = '0;
            reqVal[i] = '0;
        end
        modelReset();

        // Reset state, with all requesters already asking.
        reqValid = '1;
        @(posedge clk);
        #1;
        checkEq("rst_req_ready", 64'(reqReady), 64'(0));
        checkEq("rst_w0en", 64'(w0en), 64'(0));
        checkEq("rst_w0addr", 64'(w0addr), 64'(0));
        checkEq("rst_w0val", 64'(w0val), 64'(0));
        checkEq("rst_rs0_busy", 64'(rs0Busy), 64'(0));
        rst = 1'b0;

        // Round-robin with every unit valid continuously.
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i]) offer(i, uop_reg_t'(10 + i), uop_val_t'(32'h100 * (c + 1) + i));
            stepCycle(1'b0, '0, '0, '0);
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 2; c++) stepCycle(1'b0, '0, '0, '0);

        // Single write.
        offer(0, 5'd5, 32'hDEADBEEF);
        stepCycle(1'b0, '0, '0, '0);
        for (int c = 0; c < 2; c++) stepCycle(1'b0, '0, '0, '0);

        // Write to x0 is consumed without a register-file write; pointer moves to 2.
        offer(1, 5'd0, 32'h1234);
        stepCycle(1'b0, '0, '0, '0);
        for (int i = 0; i < N; i++) offer(i, uop_reg_t'(20 + i), uop_val_t'(32'hA0 + i));
        stepCycle(1'b0, '0, '0, '0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        stepCycle(1'b0, '0, '0, '0);

        // RAW tracking on x7; x0 source is never busy.
        stepCycle(1'b1, 5'd7, 5'd7, 5'd0);
        stepCycle(1'b0, '0, 5'd7, 5'd0);
        offer(2, 5'd7, 32'h77);
        for (int c = 0; c < 4; c++) stepCycle(1'b0, '0, 5'd7, 5'd0);

        // Set and clear of x9 on the same edge.
        offer(0, 5'd9, 32'h99);
        stepCycle(1'b0, '0, 5'd9, 5'd9);
        stepCycle(1'b1, 5'd9, 5'd9, 5'd9);
        for (int c = 0; c < 3; c++) stepCycle(1'b0, '0, 5'd9, 5'd9);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    offer(i, uop_reg_t'($urandom_range(0, 15)), uop_val_t'($urandom));
            stepCycle(logic'($urandom_range(0, 2) == 0), uop_reg_t'($urandom_range(0, 15)),
                      uop_reg_t'($urandom_range(0, 15)), uop_reg_t'($urandom_range(0, 15)));
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 3; c++) stepCycle(1'b0, '0, '0, '0);

        // Async reset while a write is in flight and x3 is busy.
        offer(0, 5'd4, 32'h4444);
        stepCycle(1'b1, 5'd3, 5'd3, 5'd3);
        for (int i = 0; i < N; i++) offer(i, uop_reg_t'(12 + i), uop_val_t'(32'hC0 + i));
        applyStimulus(1'b0, '0, 5'd3, 5'd3);
        #1;
        checkEq("pre_rst_w0en", 64'(w0en), 64'(1));
        checkEq("pre_rst_rs0_busy", 64'(rs0Busy), 64'(1));
        rst = 1'b1;
        #1;
        checkEq("async_rst_w0en", 64'(w0en), 64'(0));
        checkEq("async_rst_rs0_busy", 64'(rs0Busy), 64'(0));
        checkEq("async_rst_rs1_busy", 64'(rs1Busy), 64'(0));
        checkEq("async_rst_req_ready", 64'(reqReady), 64'(0));
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) stepCycle(1'b0, '0, 5'd3, 5'd3);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 3; c++) stepCycle(1'b0, '0, '0, '0);

        checkEq("queue_drained", 64'(expQ.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
